// File: rtl/ps2_scancode_receiver_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
// Frame states, prefix codes and data width.
package ps2_scancode_receiver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam logic [7:0] SC_EXT        = 8'hE0;
    localparam logic [7:0] SC_BREAK      = 8'hF0;
    localparam int         PS2_DATA_BITS = 8;

endpackage

// File: rtl/ps2_scancode_receiver_if.sv
// Decoded key-event bundle from the PS/2 receiver
// to the character control unit.
interface ps2_scancode_receiver_if;

    logic [7:0] ScanCode;
    logic       Extended;
    logic       Break;
    logic       CodeValid;
    logic       FrameError;

    modport master (
        output ScanCode,
        output Extended,
        output Break,
        output CodeValid,
        output FrameError
    );

    modport slave (
        input ScanCode,
        input Extended,
        input Break,
        input CodeValid,
        input FrameError
    );

endinterface

// File: rtl/ps2_scancode_receiver_sync_edge.sv
// Synchronises the raw PS/2 lines and produces a registered
// falling-edge strobe on the clock line with aligned data.
module ps2_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic PS2Clk,
    input  logic PS2Dat,
    output logic dat_s,
    output logic clk_fall
);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   clk_cur;

    assign clk_cur = clk_sync[SYNC_STAGES-1];

    // dat_s is delayed one extra flop so it lines up with clk_fall
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
            dat_s    <= 1'b1;
            clk_fall <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], PS2Clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], PS2Dat};
            clk_prev <= clk_cur;
            dat_s    <= dat_sync[SYNC_STAGES-1];
            clk_fall <= clk_prev & ~clk_cur;
        end
    end

endmodule

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard frame receiver: deframes, checks parity,
// folds E0/F0 prefixes into flags and strobes one code per key event.
module ps2_scancode_receiver
    import ps2_scancode_receiver_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                            Clock,
    input  logic                            Resetn,
    input  logic                            PS2Clk,
    input  logic                            PS2Dat,
    ps2_scancode_receiver_if.master         rx
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          dat_s;
    logic          clk_fall;
    state_t        state,     state_nxt;
    logic [7:0]    shreg,     shreg_nxt;
    logic [2:0]    bitcnt,    bitcnt_nxt;
    logic          perr,      perr_nxt;
    logic [TW-1:0] tcnt,      tcnt_nxt;
    logic          ext_pend,  ext_pend_nxt;
    logic          brk_pend,  brk_pend_nxt;
    logic [7:0]    code_q,    code_nxt;
    logic          ext_q,     ext_nxt;
    logic          brk_q,     brk_nxt;
    logic          cv_q,      cv_nxt;
    logic          fe_q,      fe_nxt;
    logic          timeout;

    ps2_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .PS2Clk   (PS2Clk),
        .PS2Dat   (PS2Dat),
        .dat_s    (dat_s),
        .clk_fall (clk_fall)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bitcnt   <= '0;
            perr     <= 1'b0;
            tcnt     <= '0;
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            code_q   <= '0;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            cv_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            bitcnt   <= bitcnt_nxt;
            perr     <= perr_nxt;
            tcnt     <= tcnt_nxt;
            ext_pend <= ext_pend_nxt;
            brk_pend <= brk_pend_nxt;
            code_q   <= code_nxt;
            ext_q    <= ext_nxt;
            brk_q    <= brk_nxt;
            cv_q     <= cv_nxt;
            fe_q     <= fe_nxt;
        end
    end

    // a fall arriving in the timeout cycle takes priority over the abort
    assign timeout = (state != ST_IDLE) && !clk_fall &&
                     (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        bitcnt_nxt   = bitcnt;
        perr_nxt     = perr;
        ext_pend_nxt = ext_pend;
        brk_pend_nxt = brk_pend;
        code_nxt     = code_q;
        ext_nxt      = ext_q;
        brk_nxt      = brk_q;
        cv_nxt       = 1'b0;
        fe_nxt       = 1'b0;
        tcnt_nxt     = tcnt;

        if (clk_fall || state == ST_IDLE) begin
            tcnt_nxt = '0;
        end else if (tcnt != '1) begin
            tcnt_nxt = tcnt + 1'b1;
        end

        if (timeout) begin
            fe_nxt       = 1'b1;
            ext_pend_nxt = 1'b0;
            brk_pend_nxt = 1'b0;
            state_nxt    = ST_IDLE;
        end else if (clk_fall) begin
            unique case (state)
                ST_IDLE: begin
                    if (!dat_s) begin
                        state_nxt  = ST_DATA;
                        bitcnt_nxt = '0;
                    end
                end
                ST_DATA: begin
                    shreg_nxt  = {dat_s, shreg[7:1]};
                    bitcnt_nxt = bitcnt + 1'b1;
                    if (bitcnt == 3'(PS2_DATA_BITS - 1)) begin
                        state_nxt = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    perr_nxt  = ~(^{shreg, dat_s});
                    state_nxt = ST_STOP;
                end
                ST_STOP: begin
                    state_nxt = ST_IDLE;
                    unique case (1'b1)
                        (!dat_s || perr): begin
                            fe_nxt       = 1'b1;
                            ext_pend_nxt = 1'b0;
                            brk_pend_nxt = 1'b0;
                        end
                        (shreg == SC_EXT): begin
                            ext_pend_nxt = 1'b1;
                        end
                        (shreg == SC_BREAK): begin
                            brk_pend_nxt = 1'b1;
                        end
                        default: begin
                            code_nxt     = shreg;
                            ext_nxt      = ext_pend;
                            brk_nxt      = brk_pend;
                            cv_nxt       = 1'b1;
                            ext_pend_nxt = 1'b0;
                            brk_pend_nxt = 1'b0;
                        end
                    endcase
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign rx.ScanCode   = code_q;
    assign rx.Extended   = ext_q;
    assign rx.Break      = brk_q;
    assign rx.CodeValid  = cv_q;
    assign rx.FrameError = fe_q;

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Directed bench for the PS/2 scan-code receiver: framing, prefixes,
// parity/stop errors, timeout, reset mid-frame and idle glitches.
module tb_ps2_scancode_receiver;

    localparam int HALF = 20;
    localparam int TMO  = 200;

    logic Clock  = 1'b0;
    logic Resetn = 1'b0;
    logic PS2Clk = 1'b1;
    logic PS2Dat = 1'b1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int fall_cyc = 0;
    int cv_cnt   = 0;
    int fe_cnt   = 0;
    int both_cnt = 0;
    int cv_cyc   = 0;
    int fe_cyc   = 0;

    ps2_scancode_receiver_if rx ();

    ps2_scancode_receiver #(
        .TIMEOUT_CYCLES (TMO),
        .SYNC_STAGES    (2)
    ) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .PS2Clk (PS2Clk),
        .PS2Dat (PS2Dat),
        .rx     (rx)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc++;

    // count every cycle a strobe is high, so a stuck strobe shows as extra counts
    always @(negedge Clock) begin
        if (rx.CodeValid) begin
            cv_cnt++;
            cv_cyc = cyc;
        end
        if (rx.FrameError) begin
            fe_cnt++;
            fe_cyc = cyc;
        end
        if (rx.CodeValid && rx.FrameError) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic ps2_bit(input logic b);
        PS2Dat = b;
        wait_cyc(HALF);
        PS2Clk   = 1'b0;
        fall_cyc = cyc;
        wait_cyc(HALF);
        PS2Clk = 1'b1;
    endtask

    task automatic send(input logic [7:0] code, input logic flip_par,
                        input logic stop, input int nbits);
        logic [10:0] f;
        f = {stop, (~^code) ^ flip_par, code, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
        PS2Dat = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    task automatic check_out(input string tag, input logic [7:0] sc,
                             input logic ext, input logic brk);
        check({tag, "_sc"},  32'(rx.ScanCode), 32'(sc));
        check({tag, "_ext"}, 32'(rx.Extended), 32'(ext));
        check({tag, "_brk"}, 32'(rx.Break),    32'(brk));
    endtask

    initial begin
        // 1: reset state, then a plain make code
        wait_cyc(3);
        check_out("rst", 8'h00, 1'b0, 1'b0);
        check("rst_cv", 32'(rx.CodeValid),  32'd0);
        check("rst_fe", 32'(rx.FrameError), 32'd0);
        Resetn = 1'b1;
        wait_cyc(5);
        send(8'h16, 1'b0, 1'b1, 11);
        check("t1_cv_cnt", cv_cnt, 1);
        check("t1_fe_cnt", fe_cnt, 0);
        // 2 sync + 1 edge register + 1 output register after the drive
        check("t1_latency", cv_cyc - fall_cyc, 4);
        check_out("t1", 8'h16, 1'b0, 1'b0);

        // 2: break prefix
        send(8'hF0, 1'b0, 1'b1, 11);
        check("t2_no_cv_f0", cv_cnt, 1);
        send(8'h16, 1'b0, 1'b1, 11);
        check("t2_cv_cnt", cv_cnt, 2);
        check_out("t2", 8'h16, 1'b0, 1'b1);

        // 3: extended break, then a plain code
        send(8'hE0, 1'b0, 1'b1, 11);
        send(8'hF0, 1'b0, 1'b1, 11);
        check("t3_no_cv_pref", cv_cnt, 2);
        send(8'h74, 1'b0, 1'b1, 11);
        check("t3_cv_cnt", cv_cnt, 3);
        check_out("t3a", 8'h74, 1'b1, 1'b1);
        send(8'h1E, 1'b0, 1'b1, 11);
        check("t3b_cv_cnt", cv_cnt, 4);
        check_out("t3b", 8'h1E, 1'b0, 1'b0);

        // 4: parity error drops frame and pending break
        send(8'hF0, 1'b0, 1'b1, 11);
        send(8'h1E, 1'b1, 1'b1, 11);
        check("t4_fe_cnt", fe_cnt, 1);
        check("t4_cv_cnt", cv_cnt, 4);
        check_out("t4_hold", 8'h1E, 1'b0, 1'b0);
        send(8'h1E, 1'b0, 1'b1, 11);
        check("t4b_cv_cnt", cv_cnt, 5);
        check_out("t4b", 8'h1E, 1'b0, 1'b0);

        // 5: stall after 4 data bits
        send(8'h1E, 1'b0, 1'b1, 5);
        for (int i = 0; i < 400 && fe_cnt < 2; i++) wait_cyc(1);
        check("t5_fe_cnt", fe_cnt, 2);
        // 3 cycles to the registered fall, 200 idle counts, 1 output register
        check("t5_tmo_cyc", fe_cyc - fall_cyc, TMO + 4);
        check("t5_cv_cnt", cv_cnt, 5);
        send(8'h1E, 1'b0, 1'b1, 11);
        check("t5b_cv_cnt", cv_cnt, 6);
        check_out("t5b", 8'h1E, 1'b0, 1'b0);

        // 6: reset mid-frame also drops a pending E0
        send(8'hE0, 1'b0, 1'b1, 11);
        send(8'h74, 1'b0, 1'b1, 6);
        Resetn = 1'b0;
        #1;
        check_out("t6_rst", 8'h00, 1'b0, 1'b0);
        wait_cyc(5);
        check("t6_cv_cnt", cv_cnt, 6);
        check("t6_fe_cnt", fe_cnt, 2);
        Resetn = 1'b1;
        wait_cyc(5);
        send(8'h16, 1'b0, 1'b1, 11);
        check("t6b_cv_cnt", cv_cnt, 7);
        check_out("t6b", 8'h16, 1'b0, 1'b0);

        // bad stop bit
        send(8'h16, 1'b0, 1'b0, 11);
        check("stop0_fe_cnt", fe_cnt, 3);
        check("stop0_cv_cnt", cv_cnt, 7);

        // fall with data high while idle is ignored
        ps2_bit(1'b1);
        wait_cyc(2 * HALF);
        check("glitch_cv_cnt", cv_cnt, 7);
        check("glitch_fe_cnt", fe_cnt, 3);
        send(8'h1E, 1'b0, 1'b1, 11);
        check("glitch_cv_next", cv_cnt, 8);
        check_out("glitch", 8'h1E, 1'b0, 1'b0);

        check("strobe_overlap", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
